// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    CMD_INC,
    CMD_JMP,
    CMD_CALL,
    CMD_RET,
    CMD_BREL
  } pc_cmd_e;

  // Fixed priority: jmp > call > ret > brel > increment.
  function automatic pc_cmd_e pc_prio(input logic jmp, input logic call,
                                      input logic ret, input logic brel);
    if (jmp)       return CMD_JMP;
    else if (call) return CMD_CALL;
    else if (ret)  return CMD_RET;
    else if (brel) return CMD_BREL;
    else           return CMD_INC;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO; push ignored when full, pop ignored when empty.
module pc_return_stack #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [DW-1:0]     depth,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [DW-1:0]     depth_q, depth_d;
  logic              push_ok, pop_ok;

  assign full    = (depth_q == DW'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty && !push;
  assign depth   = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (push_ok)     depth_d = depth_q + 1'b1;
    else if (pop_ok) depth_d = depth_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (push_ok && DW'(i) == depth_q) mem_q[i] <= din;
  end

  // Combinational read at depth-1 so ret completes in one cycle.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (DW'(i + 1) == depth_q) top = mem_q[i];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: jump, call/return, relative branch, increment.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W                 = 12,
  parameter int STACK_DEPTH            = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int DW                    = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic              brel,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [DW-1:0]     depth,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              ovf,
  output logic              unf
);

  pc_cmd_e           cmd;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, stk_top;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              do_call, do_ret;

  assign cmd     = pc_prio(jmp, call, ret, brel);
  assign pc_inc  = pc_q + 1'b1;
  assign do_call = en && (cmd == CMD_CALL);
  assign do_ret  = en && (cmd == CMD_RET);

  pc_return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (do_call),
    .pop   (do_ret),
    .din   (pc_inc),
    .top   (stk_top),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      unique case (cmd)
        CMD_JMP:  pc_d = target;
        CMD_CALL: pc_d = stk_full  ? pc_inc : target;
        CMD_RET:  pc_d = stk_empty ? pc_inc : stk_top;
        CMD_BREL: pc_d = pc_q + offset;
        default:  pc_d = pc_inc;
      endcase
    end
  end

  // A new error event outranks a simultaneous clear.
  always_comb begin
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (do_call && stk_full)  ovf_d = 1'b1;
    if (do_ret  && stk_empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc  = pc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule
